// File: rtl/ball_physics_pkg.sv
// Shared geometry, FSM state encoding and ball kinematics payload for the
// ball_physics engine and its brick_locator helper.
package ball_physics_pkg;

    // Screen, brick grid, paddle and ball geometry (pixels).
    localparam int unsigned SCREEN_W  = 800;
    localparam int unsigned SCREEN_H  = 600;
    localparam int unsigned GRID_X0   = 16;
    localparam int unsigned GRID_Y0   = 64;
    localparam int unsigned BRICK_W   = 48;
    localparam int unsigned BRICK_H   = 16;
    localparam int unsigned GRID_COLS = 16;
    localparam int unsigned GRID_ROWS = 8;
    localparam int unsigned PADDLE_W  = 80;
    localparam int unsigned PADDLE_Y  = 560;
    localparam int unsigned BALL_SIZE = 8;
    localparam int unsigned SPEED     = 3;

    localparam int unsigned PIX_W     = 10;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned VEL_W     = 4;

    // Derived positions.
    localparam int unsigned BALL_X_MAX  = SCREEN_W - BALL_SIZE;             // 792
    localparam int unsigned REST_Y      = PADDLE_Y - BALL_SIZE;             // 552
    localparam int unsigned HALF_BALL   = BALL_SIZE / 2;                    // 4
    localparam int unsigned PADDLE_OFS  = PADDLE_W / 2 - BALL_SIZE / 2;     // 36
    localparam int unsigned RESET_X     = SCREEN_W / 2 - BALL_SIZE / 2;     // 396

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,        // MOVE wait sub-state: idle until the next frame strobe
        S_MOVE,
        S_PROBE,
        S_PROBE_WAIT,
        S_RESOLVE,
        S_COMMIT
    } state_e;

    // Ball position (top-left corner) and velocity.
    typedef struct packed {
        logic [PIX_W-1:0]        x;
        logic [PIX_W-1:0]        y;
        logic signed [VEL_W-1:0] dx;
        logic signed [VEL_W-1:0] dy;
    } ball_t;

    localparam ball_t BALL_RESET = '{
        x:  PIX_W'(RESET_X),
        y:  PIX_W'(REST_Y),
        dx: 4'sd1,
        dy: -4'sd3
    };

    // Horizontal rebound speed from the ball-centre offset along the paddle.
    function automatic logic signed [VEL_W-1:0] paddle_dx(input logic signed [10:0] ofs);
        logic signed [VEL_W-1:0] r;
        if (ofs < 11'sd20)      r = -4'sd3;
        else if (ofs < 11'sd40) r = -4'sd1;
        else if (ofs < 11'sd60) r = 4'sd1;
        else                    r = 4'sd3;
        return r;
    endfunction

endpackage

// File: rtl/brick_locator.sv
// Maps a ball centre (cx,cy) to the brick grid cell under it.
// Ports: cx, cy (pixel centre) -> in_grid_c (centre lies on the grid),
//        addr_c ({row[2:0], col[3:0]}, meaningful only when in_grid_c).
module brick_locator
    import ball_physics_pkg::*;
(
    input  logic [PIX_W-1:0]  cx,
    input  logic [PIX_W-1:0]  cy,
    output logic              in_grid_c,
    output logic [ADDR_W-1:0] addr_c
);

    logic [3:0] col;
    logic [2:0] row;

    // Column via a threshold chain on brick left edges, no divider needed.
    always_comb begin
        in_grid_c = (cx >= PIX_W'(GRID_X0))
                 && (cx <  PIX_W'(GRID_X0 + GRID_COLS * BRICK_W))
                 && (cy >= PIX_W'(GRID_Y0))
                 && (cy <  PIX_W'(GRID_Y0 + GRID_ROWS * BRICK_H));
        col = '0;
        for (int unsigned k = 1; k < GRID_COLS; k++) begin
            if (cx >= PIX_W'(GRID_X0 + k * BRICK_W)) col = 4'(k);
        end
        row    = 3'((cy - PIX_W'(GRID_Y0)) >> $clog2(BRICK_H));
        addr_c = {row, col};
    end

endmodule

// File: rtl/ball_physics.sv
// Per-frame ball motion and collision engine. On FRAME_DONE the ball is
// stepped, walls/paddle/floor resolved, one brick probed through the brick
// memory port, and the new position committed within 5 cycles.
// Ports: CLK, RST_N (sync, active-low), FRAME_DONE (step strobe), LAUNCH,
//        PADDLE_X_PIXEL (paddle left edge), BALL_X/Y_PIXEL (ball position),
//        BLOCK_ADDR / BLOCK_ALIVE / BLOCK_KILL (brick memory port),
//        BRICK_HIT (score pulse), BALL_LOST (floor pulse).
module ball_physics
    import ball_physics_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FRAME_DONE,
    input  logic              LAUNCH,
    input  logic [PIX_W-1:0]  PADDLE_X_PIXEL,
    output logic [PIX_W-1:0]  BALL_X_PIXEL,
    output logic [PIX_W-1:0]  BALL_Y_PIXEL,
    output logic [ADDR_W-1:0] BLOCK_ADDR,
    input  logic              BLOCK_ALIVE,
    output logic              BLOCK_KILL,
    output logic              BRICK_HIT,
    output logic              BALL_LOST
);

    localparam logic signed [10:0] X_MAX_S    = 11'(BALL_X_MAX);
    localparam logic signed [10:0] BALL_S     = 11'(BALL_SIZE);
    localparam logic signed [10:0] HALF_S     = 11'(HALF_BALL);
    localparam logic signed [10:0] PADDLE_Y_S = 11'(PADDLE_Y);
    localparam logic signed [10:0] PADDLE_W_S = 11'(PADDLE_W);
    localparam logic signed [10:0] REST_Y_S   = 11'(REST_Y);
    localparam logic signed [10:0] FLOOR_S    = 11'(SCREEN_H);
    localparam logic signed [3:0]  SPEED_S    = 4'(SPEED);

    state_e state_q, state_d;
    ball_t  ball_q, ball_d;     // committed position/velocity
    ball_t  work_q, work_d;     // candidate for this frame
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic kill_q, kill_d, hit_q, hit_d, lost_q, lost_d;

    logic signed [10:0] nx, ny, px;
    logic signed [3:0]  ndx, ndy;
    logic               paddle_hit_c, mv_lost_c, loc_in_grid_c;
    ball_t              mv_ball_c;
    logic [ADDR_W-1:0]  loc_addr_c;

    function automatic logic signed [10:0] sext_vel(input logic signed [3:0] v);
        return $signed({{7{v[3]}}, v});
    endfunction

    function automatic logic signed [3:0] abs_vel(input logic signed [3:0] v);
        return v[3] ? -v : v;
    endfunction

    // One motion step from the committed ball: walls, paddle, then floor.
    always_comb begin
        px  = $signed({1'b0, PADDLE_X_PIXEL});
        nx  = $signed({1'b0, ball_q.x}) + sext_vel(ball_q.dx);
        ny  = $signed({1'b0, ball_q.y}) + sext_vel(ball_q.dy);
        ndx = ball_q.dx;
        ndy = ball_q.dy;
        if (nx < 11'sd0) begin
            nx  = 11'sd0;
            ndx = abs_vel(ball_q.dx);
        end else if (nx > X_MAX_S) begin
            nx  = X_MAX_S;
            ndx = -abs_vel(ball_q.dx);
        end
        if (ny < 11'sd0) begin
            ny  = 11'sd0;
            ndy = SPEED_S;
        end
        // Falling ball whose bottom edge crosses the paddle top this frame.
        paddle_hit_c = !ball_q.dy[3]
                    && ($signed({1'b0, ball_q.y}) + BALL_S <= PADDLE_Y_S)
                    && (ny + BALL_S > PADDLE_Y_S)
                    && (nx + BALL_S > px)
                    && (nx < px + PADDLE_W_S);
        if (paddle_hit_c) begin
            ny  = REST_Y_S;
            ndy = -SPEED_S;
            ndx = paddle_dx(nx + HALF_S - px);
        end
        mv_lost_c    = (ny >= FLOOR_S);
        mv_ball_c.x  = nx[PIX_W-1:0];
        mv_ball_c.y  = ny[PIX_W-1:0];
        mv_ball_c.dx = ndx;
        mv_ball_c.dy = ndy;
    end

    brick_locator u_locator (
        .cx        (work_q.x + PIX_W'(HALF_BALL)),
        .cy        (work_q.y + PIX_W'(HALF_BALL)),
        .in_grid_c (loc_in_grid_c),
        .addr_c    (loc_addr_c)
    );

    // Frame sequencer.
    always_comb begin
        state_d = state_q;
        ball_d  = ball_q;
        work_d  = work_q;
        addr_d  = addr_q;
        kill_d  = 1'b0;
        hit_d   = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (FRAME_DONE) begin
                    ball_d.x = PADDLE_X_PIXEL + PIX_W'(PADDLE_OFS);
                    ball_d.y = PIX_W'(REST_Y);
                    if (LAUNCH) begin
                        ball_d.dx = 4'sd1;
                        ball_d.dy = -SPEED_S;
                        state_d   = S_MOVE;
                    end
                end
            end
            S_WAIT: begin
                if (FRAME_DONE) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (mv_lost_c) begin
                    lost_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    work_d  = mv_ball_c;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                if (loc_in_grid_c) begin
                    addr_d  = loc_addr_c;
                    state_d = S_PROBE_WAIT;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_PROBE_WAIT: state_d = S_RESOLVE;
            S_RESOLVE: begin
                // Bounce off the brick without entering it.
                if (BLOCK_ALIVE) begin
                    kill_d    = 1'b1;
                    hit_d     = 1'b1;
                    work_d.dy = -work_q.dy;
                    work_d.y  = ball_q.y;
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                ball_d  = work_q;
                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ball_q  <= BALL_RESET;
            work_q  <= BALL_RESET;
            addr_q  <= '0;
            kill_q  <= 1'b0;
            hit_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ball_q  <= ball_d;
            work_q  <= work_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
            hit_q   <= hit_d;
            lost_q  <= lost_d;
        end
    end

    assign BALL_X_PIXEL = ball_q.x;
    assign BALL_Y_PIXEL = ball_q.y;
    assign BLOCK_ADDR   = addr_q;
    assign BLOCK_KILL   = kill_q;
    assign BRICK_HIT    = hit_q;
    assign BALL_LOST    = lost_q;

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: a per-frame arithmetic model of the game rules is
// stepped alongside the DUT, with a behavioural brick memory attached.
module tb_ball_physics;

    logic       clk = 1'b0;
    logic       rst_n, frame_done, launch, block_alive;
    logic [9:0] paddle_x, ball_x, ball_y;
    logic [6:0] block_addr;
    logic       block_kill, brick_hit, ball_lost;

    always #5 clk = ~clk;

    ball_physics dut (
        .CLK(clk), .RST_N(rst_n), .FRAME_DONE(frame_done), .LAUNCH(launch),
        .PADDLE_X_PIXEL(paddle_x), .BALL_X_PIXEL(ball_x), .BALL_Y_PIXEL(ball_y),
        .BLOCK_ADDR(block_addr), .BLOCK_ALIVE(block_alive), .BLOCK_KILL(block_kill),
        .BRICK_HIT(brick_hit), .BALL_LOST(ball_lost)
    );

    // Brick memory: one-cycle read latency, write-clear on kill.
    bit mem_alive [128] = '{default: 1'b1};
    always @(posedge clk) begin
        block_alive <= mem_alive[block_addr];
        if (block_kill) mem_alive[block_addr] <= 1'b0;
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state and per-frame expectations.
    int m_x, m_y, m_dx, m_dy;
    bit m_idle;
    bit m_alive [128] = '{default: 1'b1};
    int e_kill, e_addr, e_lost, e_probe, e_paddr;

    // Observations from one frame.
    int o_kill, o_hit, o_lost, o_kill_addr;
    int o_x5, o_y5, o_xe, o_ye;

    function automatic void model_reset();
        m_x = 396; m_y = 552; m_dx = 1; m_dy = -3; m_idle = 1'b1;
    endfunction

    function automatic void model_frame(input int px, input bit lch);
        int nx, ny, ndx, ndy, o, cx, cy, a;
        bit hit;
        e_kill = 0; e_lost = 0; e_addr = -1; e_probe = 0; e_paddr = -1;
        if (m_idle) begin
            m_x = px + 36; m_y = 552;
            if (!lch) return;
            m_dx = 1; m_dy = -3; m_idle = 1'b0;
        end
        nx = m_x + m_dx; ny = m_y + m_dy; ndx = m_dx; ndy = m_dy;
        if (nx < 0)        begin nx = 0;   ndx = (m_dx < 0) ? -m_dx : m_dx; end
        else if (nx > 792) begin nx = 792; ndx = (m_dx < 0) ? m_dx : -m_dx; end
        if (ny < 0) begin ny = 0; ndy = 3; end
        hit = (m_dy > 0) && (m_y + 8 <= 560) && (ny + 8 > 560) && (nx + 8 > px) && (nx < px + 80);
        if (hit) begin
            ny = 552; ndy = -3; o = nx + 4 - px;
            ndx = (o < 20) ? -3 : (o < 40) ? -1 : (o < 60) ? 1 : 3;
        end
        if (ny >= 600) begin e_lost = 1; m_idle = 1'b1; return; end
        cx = nx + 4; cy = ny + 4;
        if (cx >= 16 && cx < 784 && cy >= 64 && cy < 192) begin
            a = ((cy - 64) / 16) * 16 + (cx - 16) / 48;
            e_probe = 1; e_paddr = a;
            if (m_alive[a]) begin
                m_alive[a] = 1'b0; e_kill = 1; e_addr = a; ndy = -ndy; ny = m_y;
            end
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    endfunction

    function automatic int track_px();
        int p;
        p = m_x - 36 + (int'($urandom_range(0, 72)) - 36);
        if (p < 0) p = 0;
        if (p > 720) p = 720;
        return p;
    endfunction

    // One frame: strobe, optional ignored second strobe, 8 observed cycles.
    task automatic run_frame(input int px, input bit lch, input bit extra);
        @(negedge clk);
        paddle_x = 10'(px); launch = lch; frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0; launch = 1'($urandom_range(0, 1));
        o_kill = 0; o_hit = 0; o_lost = 0; o_kill_addr = -1;
        for (int c = 1; c <= 8; c++) begin
            if (extra && c == 1) frame_done = 1'b1;
            @(negedge clk);
            if (c == 1) frame_done = 1'b0;
            if (block_kill) begin o_kill++; o_kill_addr = int'(block_addr); end
            if (brick_hit) o_hit++;
            if (ball_lost) o_lost++;
            if (c == 5) begin o_x5 = int'(ball_x); o_y5 = int'(ball_y); end
            if (c == 8) begin o_xe = int'(ball_x); o_ye = int'(ball_y); end
        end
        launch = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_done = 1'b0; launch = 1'b0; paddle_x = 10'd360;
        repeat (3) @(negedge clk);
        n_cmp++; if (ball_x !== 10'd396) begin n_fail++; $display("FAIL reset_x got %0d want 396", ball_x); end
        n_cmp++; if (ball_y !== 10'd552) begin n_fail++; $display("FAIL reset_y got %0d want 552", ball_y); end
        n_cmp++; if (block_addr !== 7'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", block_addr); end
        n_cmp++; if ({block_kill, brick_hit, ball_lost} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got %b want 000", {block_kill, brick_hit, ball_lost}); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_follow();
        for (int i = 0; i < 4; i++) begin
            int px;
            px = (i == 0) ? 300 : int'($urandom_range(0, 720));
            model_frame(px, 1'b0);
            run_frame(px, 1'b0, 1'b0);
            n_cmp++; if (o_x5 != m_x || o_y5 != m_y) begin
                n_fail++; $display("FAIL idle_pos px=%0d got (%0d,%0d) want (%0d,%0d)", px, o_x5, o_y5, m_x, m_y); end
            n_cmp++; if (o_kill + o_hit + o_lost != 0) begin
                n_fail++; $display("FAIL idle_strobes got %0d want 0", o_kill + o_hit + o_lost); end
        end
    endtask

    task automatic test_launch();
        model_frame(360, 1'b1);
        run_frame(360, 1'b1, 1'b0);
        n_cmp++; if (o_x5 != m_x || o_y5 != m_y) begin
            n_fail++; $display("FAIL launch_pos got (%0d,%0d) want (%0d,%0d)", o_x5, o_y5, m_x, m_y); end
        n_cmp++; if (o_x5 != 397 || o_y5 != 549) begin
            n_fail++; $display("FAIL launch_abs got (%0d,%0d) want (397,549)", o_x5, o_y5); end
        // Second step exposes the launch velocity.
        model_frame(360, 1'b0);
        run_frame(360, 1'b0, 1'b0);
        n_cmp++; if (o_x5 != 398 || o_y5 != 546) begin
            n_fail++; $display("FAIL launch_step2 got (%0d,%0d) want (398,546)", o_x5, o_y5); end
    endtask

    task automatic test_play(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            int px;
            bit lch, extra;
            px  = m_idle ? int'($urandom_range(0, 720)) : track_px();
            lch = m_idle ? 1'b1 : 1'($urandom_range(0, 1));
            model_frame(px, lch);
            extra = (e_lost == 0) && ($urandom_range(0, 3) == 0);
            run_frame(px, lch, extra);
            n_cmp++; if (o_x5 != m_x || o_y5 != m_y) begin
                n_fail++; $display("FAIL play_pos5 f=%0d got (%0d,%0d) want (%0d,%0d)", f, o_x5, o_y5, m_x, m_y); end
            n_cmp++; if (o_xe != o_x5 || o_ye != o_y5) begin
                n_fail++; $display("FAIL play_hold f=%0d got (%0d,%0d) want (%0d,%0d)", f, o_xe, o_ye, o_x5, o_y5); end
            n_cmp++; if (o_kill != e_kill || o_hit != e_kill) begin
                n_fail++; $display("FAIL play_kill f=%0d got kill=%0d hit=%0d want %0d", f, o_kill, o_hit, e_kill); end
            n_cmp++; if (o_lost != e_lost) begin
                n_fail++; $display("FAIL play_lost f=%0d got %0d want %0d", f, o_lost, e_lost); end
            if (e_kill != 0) begin
                n_cmp++; if (o_kill_addr != e_addr) begin
                    n_fail++; $display("FAIL play_kill_addr f=%0d got 0x%0h want 0x%0h", f, o_kill_addr, e_addr); end
            end
        end
    endtask

    task automatic test_ball_lost();
        bit seen;
        seen = 1'b0;
        for (int f = 0; f < 600 && !seen; f++) begin
            int px;
            bit lch;
            px  = (m_x < 400) ? 720 : 0;
            lch = m_idle;
            model_frame(px, lch);
            run_frame(px, lch, 1'b0);
            n_cmp++; if (o_lost != e_lost || o_x5 != m_x || o_y5 != m_y) begin
                n_fail++; $display("FAIL lost_frame f=%0d got lost=%0d (%0d,%0d) want lost=%0d (%0d,%0d)",
                                   f, o_lost, o_x5, o_y5, e_lost, m_x, m_y); end
            if (e_lost != 0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL lost_timeout got no loss want loss within 600 frames"); end
        // Back in IDLE the ball rides the paddle again.
        model_frame(200, 1'b0);
        run_frame(200, 1'b0, 1'b0);
        n_cmp++; if (o_x5 != 236 || o_y5 != 552) begin
            n_fail++; $display("FAIL lost_idle got (%0d,%0d) want (236,552)", o_x5, o_y5); end
    endtask

    task automatic test_reset_mid_probe();
        bit found;
        int kills;
        found = 1'b0;
        for (int f = 0; f < 800 && !found; f++) begin
            int px;
            bit lch;
            px  = m_idle ? int'($urandom_range(0, 720)) : track_px();
            lch = m_idle;
            model_frame(px, lch);
            if (e_probe != 0) begin
                found = 1'b1;
                @(negedge clk); paddle_x = 10'(px); launch = lch; frame_done = 1'b1;
                @(negedge clk); frame_done = 1'b0; launch = 1'b0;
                repeat (2) @(negedge clk);
                n_cmp++; if (int'(block_addr) != e_paddr) begin
                    n_fail++; $display("FAIL probe_addr got 0x%0h want 0x%0h", block_addr, e_paddr); end
                rst_n = 1'b0;
                @(negedge clk);
                n_cmp++; if (ball_x !== 10'd396 || ball_y !== 10'd552 || block_addr !== 7'd0) begin
                    n_fail++; $display("FAIL midrst_pos got (%0d,%0d) addr=%0d want (396,552) addr=0", ball_x, ball_y, block_addr); end
                n_cmp++; if ({block_kill, brick_hit, ball_lost} !== 3'b000) begin
                    n_fail++; $display("FAIL midrst_strobes got %b want 000", {block_kill, brick_hit, ball_lost}); end
                kills = 0;
                @(negedge clk); if (block_kill) kills++;
                rst_n = 1'b1;
                repeat (6) begin @(negedge clk); if (block_kill) kills++; end
                n_cmp++; if (kills != 0 || ball_x !== 10'd396 || ball_y !== 10'd552) begin
                    n_fail++; $display("FAIL midrst_after got kills=%0d (%0d,%0d) want 0 (396,552)", kills, ball_x, ball_y); end
                if (e_kill != 0) m_alive[e_addr] = 1'b1;
                model_reset();
            end else begin
                run_frame(px, lch, 1'b0);
                n_cmp++; if (o_xe != m_x || o_ye != m_y || o_lost != e_lost) begin
                    n_fail++; $display("FAIL seek_frame f=%0d got (%0d,%0d) want (%0d,%0d)", f, o_xe, o_ye, m_x, m_y); end
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL probe_timeout got no probe frame want one within 800"); end
    endtask

    initial begin
        test_reset();
        test_idle_follow();
        test_launch();
        test_play(1500);
        test_ball_lost();
        test_reset_mid_probe();
        test_play(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_physics.md
# ball_physics

Per-frame ball motion and collision engine; it feeds the ball position consumed by the game renderer. On each `FRAME_DONE` strobe it advances the ball by its velocity. It then resolves wall, paddle, brick and floor collisions, and updates the brick memory through its own read/write port. The ball position outputs are stable for the entire visible part of every frame.

## Interface
- `PADDLE_W`, 80: paddle width in px; `PADDLE_X_PIXEL` is the paddle's left edge.
- `PADDLE_Y`, 560: top row of the paddle.
- `BALL_SIZE`, 8: ball edge length in px; ball position is its top-left corner.
- `SPEED`, 3: magnitude of the vertical velocity in px/frame.

Ports (clock and reset first):
- `CLK` input 1: system clock. One clock domain only.
- `RST_N` input 1: reset, synchronous and active-low.
- `FRAME_DONE` input 1: one-cycle step strobe, one per frame.
- `LAUNCH` input 1: level; releases the ball from the paddle.
- `PADDLE_X_PIXEL` input 10: paddle left edge, range 0..720.
- `BALL_X_PIXEL` output 10: registered ball x position.
- `BALL_Y_PIXEL` output 10: registered ball y position.
- `BLOCK_ADDR` output 7: brick memory port address, `{row[2:0], col[3:0]}`.
- `BLOCK_ALIVE` input 1: read data, valid 1 cycle after `BLOCK_ADDR`.
- `BLOCK_KILL` output 1: one-cycle write strobe that clears the brick at `BLOCK_ADDR`.
- `BRICK_HIT` output 1: one-cycle pulse per destroyed brick (for score).
- `BALL_LOST` output 1: one-cycle pulse when the ball leaves through the floor.

## Operation
- **States:** IDLE, MOVE, PROBE, PROBE_WAIT, RESOLVE, COMMIT.
- **IDLE:** the ball rides the paddle.
  - On `FRAME_DONE`: X = `PADDLE_X_PIXEL`+36, Y = 552.
  - If `LAUNCH`=1 at that strobe: set velocity (dx,dy) = (+1,−3), go to MOVE.
  - `LAUNCH` is ignored in all other states.
- **MOVE** (entered on `FRAME_DONE`, or directly from IDLE on launch):
  - nx = X+dx, ny = Y+dy, computed 11-bit signed.
  - Walls: nx<0 → nx=0, dx=+|dx|; nx>792 → nx=792, dx=−|dx|; ny<0 → ny=0, dy=+SPEED.
  - Paddle hit when all hold: dy>0; Y+8 ≤ 560 < ny+8; nx+8 > paddle_x; nx < paddle_x+80.
  - On a paddle hit: ny=552, dy=−SPEED, dx from centre offset o=(nx+4)−paddle_x:
    - o<20 → −3
    - o<40 → −1
    - o<60 → +1
    - otherwise → +3
  - Floor: ny ≥ 600 → pulse `BALL_LOST`, go to IDLE without committing.
- **PROBE:** compute centre cx=nx+4, cy=ny+4.
  - Inside the grid (16 ≤ cx < 784, 64 ≤ cy < 192): col = (cx−16)/48 via a constant comparison chain (no divider); row = (cy−64)>>4. Drive `BLOCK_ADDR`, go to PROBE_WAIT.
  - Outside the grid: go to COMMIT.
- **PROBE_WAIT:** wait one cycle for memory latency.
- **RESOLVE:** if `BLOCK_ALIVE`=1:
  - pulse `BLOCK_KILL` and `BRICK_HIT` in the same cycle;
  - negate dy;
  - set ny = Y, so the ball does not enter the brick.
- **COMMIT:** load X,Y from nx,ny, go to the wait sub-state of MOVE (await next `FRAME_DONE`).
- Only one brick is destroyed per frame.
- `FRAME_DONE` arriving outside IDLE or the MOVE wait is ignored.

## Timing
- **Reset values:**
  - X=396, Y=552, dx=+1, dy=−SPEED, state IDLE.
  - `BLOCK_ADDR`=0.
  - `BLOCK_KILL`, `BRICK_HIT`, `BALL_LOST` all 0.
- **Latency:** `BALL_X_PIXEL`/`BALL_Y_PIXEL` update at most 5 cycles after `FRAME_DONE`. They are held constant otherwise. This is far inside vertical blanking.
- **Brick port:** `BLOCK_ADDR` is held stable from PROBE through RESOLVE. `BLOCK_KILL` coincides with the final address.
- **Reset mid-sequence:** reset wins in the same edge. Strobes drop immediately; no partial commit occurs.
- **Same-frame events:** a wall and a paddle hit resolve on separate axes. The floor check runs after the paddle check, so a paddle catch overrides loss.

## Structure
- The shared geometry constants file holds: screen 800×600, brick grid origin (16,64), brick size 48×16, 16×8 grid, paddle and ball sizes, `SPEED`.
- One sub-module, `brick_locator`: combinational mapping of (cx,cy) to {in_grid, addr}. It is tested standalone.

## Test plan
- Reset, paddle at 300, `FRAME_DONE` with no `LAUNCH` → ball at (336,552); no strobes.
- Launch from X=396,Y=552 → after one step, ball at (397,549) and dy=−3.
- Ball at (790,100), dx=+3, no brick alive → X=792, dx=−3.
- Ball at (100,120), dy=−3, brick {3,1} alive → `BLOCK_ADDR`=0x31, `BLOCK_KILL`/`BRICK_HIT` pulse once, Y stays 120, dy=+3.
- Ball at (345,550), dy=+3, paddle at 300 → Y=552, dy=−3, dx=+1; with paddle at 500 instead, continue to Y≥600 → `BALL_LOST` pulse, IDLE.
- Assert `RST_N`=0 during PROBE_WAIT → next cycle all outputs at reset values, no `BLOCK_KILL`.
